// File: rtl/quad_encoder_ctrl.sv
// Quadrature encoder controller: pin sync, tick-based stability filter, Gray decode FSM and
// wrapping signed position count with snapshot read. Define ENC_DETENT_EN for one count per detent.
module quad_encoder_ctrl #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned TICK_DIV = 100,
  parameter int unsigned STABLE_N = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             en,
  input  logic             clr,
  input  logic             rd_stb,
  output logic [CNT_W-1:0] rd_data,
  output logic             rd_valid,
  output logic [CNT_W-1:0] count,
  output logic             step_cw,
  output logic             step_ccw,
  output logic             err
);

  localparam int unsigned TCNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SCNT_W = $clog2(STABLE_N + 1);

  typedef enum logic [2:0] {INIT, S00, S10, S11, S01} state_t;

  function automatic logic [1:0] st_ab(input state_t s);
    case (s)
      S10:     st_ab = 2'b10;
      S11:     st_ab = 2'b11;
      S01:     st_ab = 2'b01;
      default: st_ab = 2'b00;
    endcase
  endfunction

  function automatic state_t ab_st(input logic [1:0] v);
    case (v)
      2'b10:   ab_st = S10;
      2'b11:   ab_st = S11;
      2'b01:   ab_st = S01;
      default: ab_st = S00;
    endcase
  endfunction

`ifndef ENC_DETENT_EN
  function automatic logic [1:0] cw_next(input logic [1:0] v);
    case (v)
      2'b00:   cw_next = 2'b10;
      2'b10:   cw_next = 2'b11;
      2'b11:   cw_next = 2'b01;
      default: cw_next = 2'b00;
    endcase
  endfunction
`endif

  logic [1:0]        a_sync, b_sync;
  logic [1:0]        ab_s;
  logic [TCNT_W-1:0] tcnt;
  logic              tick_c;
  logic [SCNT_W-1:0] scnt, scnt_nxt;
  logic              stable_c;
  logic [1:0]        last_sample, ab_acc;
  logic              new_q, stable_q;
  state_t            state, state_nxt;
  logic [1:0]        cur_ab;
  logic              inc_c, dec_c, ill_c;

  // Two-flop synchronisers on the raw pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sync <= 2'b00;
      b_sync <= 2'b00;
    end else begin
      a_sync <= {a_sync[0], a_in};
      b_sync <= {b_sync[0], b_in};
    end
  end

  assign ab_s   = {a_sync[1], b_sync[1]};
  assign tick_c = en && (tcnt == TCNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      tcnt <= '0;
    else if (tick_c) tcnt <= '0;
    else if (en)     tcnt <= tcnt + TCNT_W'(1);
  end

  // Stability counter saturates at STABLE_N; any differing sample restarts it at 1
  always_comb begin
    scnt_nxt = SCNT_W'(1);
    if (ab_s == last_sample)
      scnt_nxt = (scnt == SCNT_W'(STABLE_N)) ? scnt : scnt + SCNT_W'(1);
  end

  assign stable_c = (scnt_nxt == SCNT_W'(STABLE_N));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt        <= '0;
      last_sample <= 2'b00;
      ab_acc      <= 2'b00;
      new_q       <= 1'b0;
      stable_q    <= 1'b0;
    end else begin
      new_q    <= tick_c && stable_c && (ab_s != ab_acc);
      stable_q <= tick_c && stable_c;
      if (tick_c) begin
        scnt        <= scnt_nxt;
        last_sample <= ab_s;
        if (stable_c && (ab_s != ab_acc)) ab_acc <= ab_s;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= INIT;
    else        state <= state_nxt;
  end

  // Strobes only arise from enabled ticks, so a strobe still in flight when en drops is consumed
  always_comb begin
    state_nxt = state;
    inc_c     = 1'b0;
    dec_c     = 1'b0;
    ill_c     = 1'b0;
    cur_ab    = st_ab(state);
    if (state == INIT) begin
      if (new_q || stable_q) state_nxt = ab_st(ab_acc);
    end else if (new_q && (ab_acc != cur_ab)) begin
      state_nxt = ab_st(ab_acc);
      if ((ab_acc ^ cur_ab) == 2'b11) begin
        ill_c = 1'b1;
      end else begin
`ifdef ENC_DETENT_EN
        if (ab_acc == 2'b00) begin
          inc_c = (cur_ab == 2'b01);
          dec_c = (cur_ab == 2'b10);
        end
`else
        if (ab_acc == cw_next(cur_ab)) inc_c = 1'b1;
        else                           dec_c = 1'b1;
`endif
      end
    end
  end

  // clr overrides a same-cycle step on the count but the pulse still goes out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      step_cw  <= 1'b0;
      step_ccw <= 1'b0;
      err      <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      step_cw  <= inc_c;
      step_ccw <= dec_c;
      rd_valid <= rd_stb;
      if (rd_stb) rd_data <= count;
      if (clr)        count <= '0;
      else if (inc_c) count <= count + CNT_W'(1);
      else if (dec_c) count <= count - CNT_W'(1);
      if (clr)        err <= 1'b0;
      else if (ill_c) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_quad_encoder_ctrl.sv
// Directed bench for quad_encoder_ctrl with a step/read scoreboard; honours ENC_DETENT_EN.
module tb_quad_encoder_ctrl;

  localparam int unsigned CNT_W = 16;
`ifdef ENC_DETENT_EN
  localparam logic [15:0] T1_CNT = 16'd1;
  localparam logic [15:0] T3_CNT = 16'h0000;
  localparam logic [15:0] T6_CNT = 16'd0;
`else
  localparam logic [15:0] T1_CNT = 16'd4;
  localparam logic [15:0] T3_CNT = 16'hFFFF;
  localparam logic [15:0] T6_CNT = 16'd3;
`endif

  logic             clk = 1'b0;
  logic             rst_n, a_in, b_in, en, clr, rd_stb;
  logic [CNT_W-1:0] rd_data, count;
  logic             rd_valid, step_cw, step_ccw, err;

  quad_encoder_ctrl #(.CNT_W(CNT_W), .TICK_DIV(4), .STABLE_N(2)) dut (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in), .en(en), .clr(clr),
    .rd_stb(rd_stb), .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
    .step_cw(step_cw), .step_ccw(step_ccw), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  dir;
    logic [15:0] cnt;
  } step_t;

  step_t       exp_q[$];
  logic [15:0] rd_q[$];
  step_t       mon_e;
  int          n_vec = 0;
  int          n_err = 0;
  logic [1:0]  mst;
  logic [15:0] mcount;
  logic        merr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] cw_nxt(input logic [1:0] v);
    case (v)
      2'b00:   cw_nxt = 2'b10;
      2'b10:   cw_nxt = 2'b11;
      2'b11:   cw_nxt = 2'b01;
      default: cw_nxt = 2'b00;
    endcase
  endfunction

  // Drive a new A/B value, predict its effect, optionally hold clr across the whole window
  task automatic drive(input logic [1:0] v, input int hold, input bit clr_win);
    logic [1:0] dir;
    dir = 2'b00;
    if (v != mst) begin
      if ((v ^ mst) == 2'b11) merr = 1'b1;
      else begin
`ifdef ENC_DETENT_EN
        if (v == 2'b00 && mst == 2'b01)      dir = 2'b10;
        else if (v == 2'b00 && mst == 2'b10) dir = 2'b01;
`else
        if (v == cw_nxt(mst)) dir = 2'b10;
        else                  dir = 2'b01;
`endif
      end
    end
    if (clr_win) begin
      mcount = 16'd0;
      merr   = 1'b0;
    end else if (dir == 2'b10) mcount = mcount + 16'd1;
    else if (dir == 2'b01)     mcount = mcount - 16'd1;
    if (dir != 2'b00) exp_q.push_back({dir, mcount});
    clr = clr_win;
    {a_in, b_in} = v;
    mst = v;
    clks(hold);
    clr = 1'b0;
  endtask

  task automatic rd(input int n);
    for (int i = 0; i < n; i++) rd_q.push_back(mcount);
    rd_stb = 1'b1;
    clks(1);
    check("rd_valid_next_clk", 32'(rd_valid), 32'd1);
    clks(n - 1);
    rd_stb = 1'b0;
    clks(2);
  endtask

  task automatic check_reset_outputs();
    check("rst_count", 32'(count), 32'd0);
    check("rst_steps", 32'({step_cw, step_ccw}), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (step_cw || step_ccw) begin
        if (exp_q.size() == 0) begin
          check("spurious_step", 32'({step_cw, step_ccw}), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("step_dir", 32'({step_cw, step_ccw}), 32'(mon_e.dir));
          check("step_count", 32'(count), 32'(mon_e.cnt));
        end
      end
      if (rd_valid) begin
        if (rd_q.size() == 0) check("spurious_rd_valid", 32'(rd_valid), 32'd0);
        else                  check("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
      end
    end
  end

  initial begin
    rst_n = 1'b0; a_in = 1'b0; b_in = 1'b0; en = 1'b1; clr = 1'b0; rd_stb = 1'b0;
    mst = 2'b00; mcount = 16'd0; merr = 1'b0;
    clks(3);
    check_reset_outputs();
    rst_n = 1'b1;
    clks(40);
    check("init_count", 32'(count), 32'd0);
    check("init_err", 32'(err), 32'd0);

    // Full CW cycle
    drive(2'b10, 20, 1'b0);
    drive(2'b11, 20, 1'b0);
    drive(2'b01, 20, 1'b0);
    drive(2'b00, 20, 1'b0);
    check("t1_count", 32'(count), 32'(T1_CNT));
    check("t1_err", 32'(err), 32'd0);
    check("t1_pulses_seen", 32'(exp_q.size()), 32'd0);

    // Short glitch on A is filtered out
    a_in = 1'b1;
    clks(3);
    a_in = 1'b0;
    clks(30);
    check("t2_count", 32'(count), 32'(T1_CNT));
    check("t2_err", 32'(err), 32'd0);
    rd(1);

    // Wrap below zero
    clr = 1'b1;
    clks(1);
    clr = 1'b0;
    mcount = 16'd0;
    merr = 1'b0;
    clks(1);
    check("t3_clr_count", 32'(count), 32'd0);
    drive(2'b01, 20, 1'b0);
    check("t3_wrap_count", 32'(count), 32'(T3_CNT));
    drive(2'b00, 20, 1'b0);

    // Illegal jump, then a legal move, then clr
    drive(2'b11, 20, 1'b0);
    check("t4_err_set", 32'(err), 32'd1);
    check("t4_count_held", 32'(count), 32'(mcount));
    drive(2'b01, 20, 1'b0);
    check("t4_count_after", 32'(count), 32'(mcount));
    check("t4_err_sticky", 32'(err), 32'(merr));
    clr = 1'b1;
    clks(1);
    clr = 1'b0;
    mcount = 16'd0;
    merr = 1'b0;
    clks(1);
    check("t4_clr_err", 32'(err), 32'd0);
    check("t4_clr_count", 32'(count), 32'd0);

    // clr coincident with a step: pulse emitted, count stays zero
    drive(2'b00, 20, 1'b1);
    check("t5_count", 32'(count), 32'd0);
    check("t5_pulse_seen", 32'(exp_q.size()), 32'd0);
    rd(1);
    rd(2);

    // Reset mid-sequence, then no spurious step on the first accepted value
    drive(2'b10, 20, 1'b0);
    drive(2'b11, 20, 1'b0);
    drive(2'b01, 20, 1'b0);
    check("t6_count_pre", 32'(count), 32'(T6_CNT));
    {a_in, b_in} = 2'b11;
    rst_n = 1'b0;
    clks(3);
    check_reset_outputs();
    mst = 2'b11; mcount = 16'd0; merr = 1'b0;
    rst_n = 1'b1;
    clks(40);
    check("t6_count_post", 32'(count), 32'd0);
    check("t6_err_post", 32'(err), 32'd0);
    drive(2'b01, 20, 1'b0);
    check("t6_first_move", 32'(count), 32'(mcount));

    // en=0 freezes decoding; the move is picked up once enabled
    en = 1'b0;
    drive(2'b00, 20, 1'b0);
    check("t7_frozen_pending", 32'(exp_q.size()), 32'd1);
    en = 1'b1;
    clks(30);
    check("t7_resumed", 32'(exp_q.size()), 32'd0);
    check("t7_count", 32'(count), 32'(mcount));

    check("final_steps_pending", 32'(exp_q.size()), 32'd0);
    check("final_rd_pending", 32'(rd_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
